// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_pkg
// Description : Shared widths, sentinels and state encodings for the draw path.
// Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

    localparam int DEFAULT_POS_W  = 11;
    localparam int DEFAULT_IDX_W  = 5;
    localparam int DEFAULT_SIZE_W = 7;

    // Off-board coordinate understood by every consumer of pixel positions.
    localparam logic [10:0] POS_INVALID = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } tile_pos_state_t;

endpackage
`default_nettype wire

// File: rtl/tile_pos_gen_acc.sv
`default_nettype none
// ============================================================================
// Module      : tile_acc
// Description : Saturating conditional accumulator with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_acc
    import draw_pkg::*;
#(
    parameter int POS_W  = DEFAULT_POS_W,
    parameter int SIZE_W = DEFAULT_SIZE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [POS_W-1:0]  load_val,
    input  logic              add_en,
    input  logic [SIZE_W-1:0] addend,
    output logic [POS_W-1:0]  value,
    output logic              ovf
);

    logic [POS_W:0] acc;
    logic [POS_W:0] sum;

    assign sum   = acc + {{(POS_W + 1 - SIZE_W){1'b0}}, addend};
    assign value = acc[POS_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            acc <= {1'b0, load_val};
            ovf <= 1'b0;
        end else if (add_en && !ovf) begin
            // Once the carry bit appears the value is pinned at the sentinel.
            if (sum[POS_W]) begin
                acc <= {1'b0, POS_INVALID};
                ovf <= 1'b1;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_pos_gen.sv
`default_nettype none
// ============================================================================
// Module      : tile_pos_gen
// Description : Tile index (col,row) to top-left pixel coordinate, iterative add.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_pos_gen
    import draw_pkg::*;
#(
    parameter int POS_W  = DEFAULT_POS_W,
    parameter int IDX_W  = DEFAULT_IDX_W,
    parameter int SIZE_W = DEFAULT_SIZE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [IDX_W-1:0]  tile_x,
    input  logic [IDX_W-1:0]  tile_y,
    input  logic [POS_W-1:0]  board_xpos,
    input  logic [POS_W-1:0]  board_ypos,
    input  logic [SIZE_W-1:0] button_size,
    input  logic [IDX_W-1:0]  button_num,
    output logic              busy,
    output logic              valid,
    output logic [POS_W-1:0]  tile_xpos,
    output logic [POS_W-1:0]  tile_ypos,
    output logic              err
);

    tile_pos_state_t   state;
    logic [IDX_W-1:0]  tx;
    logic [IDX_W-1:0]  ty;
    logic [IDX_W-1:0]  m;
    logic [IDX_W-1:0]  ctr;
    logic [SIZE_W-1:0] size_q;
    logic              range_err;

    logic              start;
    logic              stepping;
    logic              add_x;
    logic              add_y;
    logic [POS_W-1:0]  acc_x;
    logic [POS_W-1:0]  acc_y;
    logic              ovf_x;
    logic              ovf_y;
    logic              any_err;

    assign start    = (state == IDLE) && req;
    assign stepping = (state == CALC) && (ctr != m);
    assign add_x    = stepping && (ctr < tx);
    assign add_y    = stepping && (ctr < ty);
    assign any_err  = range_err || ovf_x || ovf_y;

    tile_acc #(.POS_W(POS_W), .SIZE_W(SIZE_W)) u_acc_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (board_xpos),
        .add_en   (add_x),
        .addend   (size_q),
        .value    (acc_x),
        .ovf      (ovf_x)
    );

    tile_acc #(.POS_W(POS_W), .SIZE_W(SIZE_W)) u_acc_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (board_ypos),
        .add_en   (add_y),
        .addend   (size_q),
        .value    (acc_y),
        .ovf      (ovf_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= '0;
            ty        <= '0;
            m         <= '0;
            ctr       <= '0;
            size_q    <= '0;
            range_err <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
            tile_xpos <= '0;
            tile_ypos <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        tx     <= tile_x;
                        ty     <= tile_y;
                        size_q <= button_size;
                        ctr    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                        // Out-of-range requests pass through one empty CALC beat,
                        // so their latency matches an m==0 conversion.
                        if ((tile_x >= button_num) || (tile_y >= button_num)) begin
                            range_err <= 1'b1;
                            m         <= '0;
                        end else begin
                            range_err <= 1'b0;
                            m         <= (tile_x > tile_y) ? tile_x : tile_y;
                        end
                    end
                end
                CALC: begin
                    if (ctr == m) begin
                        state <= DONE;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                DONE: begin
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    err       <= any_err;
                    tile_xpos <= any_err ? POS_INVALID : acc_x;
                    tile_ypos <= any_err ? POS_INVALID : acc_y;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_pos_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_pos_gen
// Description : Directed self-checking bench for tile_pos_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_pos_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [4:0]  tile_x;
    logic [4:0]  tile_y;
    logic [10:0] board_xpos;
    logic [10:0] board_ypos;
    logic [6:0]  button_size;
    logic [4:0]  button_num;
    logic        busy;
    logic        valid;
    logic [10:0] tile_xpos;
    logic [10:0] tile_ypos;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_pos_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .tile_x      (tile_x),
        .tile_y      (tile_y),
        .board_xpos  (board_xpos),
        .board_ypos  (board_ypos),
        .button_size (button_size),
        .button_num  (button_num),
        .busy        (busy),
        .valid       (valid),
        .tile_xpos   (tile_xpos),
        .tile_ypos   (tile_ypos),
        .err         (err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, scrambles inputs after the sampling edge, and waits
    // for valid. lat = edges after the sampling edge (-1 on timeout).
    task automatic convert(input logic [10:0] bx, input logic [10:0] by,
                           input logic [6:0] sz, input logic [4:0] nm,
                           input logic [4:0] tx, input logic [4:0] ty,
                           output int lat, output int bcyc);
        board_xpos  = bx;
        board_ypos  = by;
        button_size = sz;
        button_num  = nm;
        tile_x      = tx;
        tile_y      = ty;
        req         = 1'b1;
        step();
        req         = 1'b0;
        board_xpos  = ~bx;
        board_ypos  = ~by;
        button_size = ~sz;
        button_num  = 5'd0;
        tile_x      = ~tx;
        tile_y      = ~ty;
        lat  = -1;
        bcyc = 0;
        for (int n = 0; n < 100; n++) begin
            if (valid) begin
                lat = n;
                break;
            end
            if (busy) bcyc++;
            step();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 1'b0;
        tile_x = 5'd0; tile_y = 5'd0;
        board_xpos = 11'd0; board_ypos = 11'd0;
        button_size = 7'd0; button_num = 5'd0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (tile_xpos !== 11'd0 || tile_ypos !== 11'd0) begin
            errors++; $display("FAIL reset_pos got (%0d,%0d) exp (0,0)", tile_xpos, tile_ypos);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_origin;
        int lat, bc;
        convert(11'd100, 11'd50, 7'd40, 5'd10, 5'd0, 5'd0, lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL origin_lat got %0d exp 2", lat); end
        checks++; if (tile_xpos !== 11'd100 || tile_ypos !== 11'd50 || err !== 1'b0) begin
            errors++; $display("FAIL origin_pos got (%0d,%0d) err %b exp (100,50) err 0", tile_xpos, tile_ypos, err);
        end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL origin_pulse got valid %b exp 0", valid); end
    endtask

    task automatic test_asymmetric;
        int lat, bc;
        convert(11'd100, 11'd50, 7'd40, 5'd10, 5'd3, 5'd7, lat, bc);
        checks++; if (lat !== 9) begin errors++; $display("FAIL asym_lat got %0d exp 9", lat); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL asym_busy got %0d exp 9", bc); end
        checks++; if (tile_xpos !== 11'd220 || tile_ypos !== 11'd330 || err !== 1'b0) begin
            errors++; $display("FAIL asym_pos got (%0d,%0d) err %b exp (220,330) err 0", tile_xpos, tile_ypos, err);
        end
        step();
    endtask

    task automatic test_range;
        int lat, bc;
        convert(11'd100, 11'd50, 7'd40, 5'd10, 5'd10, 5'd2, lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL range_lat got %0d exp 2", lat); end
        checks++; if (err !== 1'b1 || tile_xpos !== 11'h7FF || tile_ypos !== 11'h7FF) begin
            errors++; $display("FAIL range_err got (%h,%h) err %b exp (7ff,7ff) err 1", tile_xpos, tile_ypos, err);
        end
        step();
        convert(11'd100, 11'd50, 7'd40, 5'd10, 5'd9, 5'd9, lat, bc);
        checks++; if (lat !== 11) begin errors++; $display("FAIL range_max_lat got %0d exp 11", lat); end
        checks++; if (tile_xpos !== 11'd460 || tile_ypos !== 11'd410 || err !== 1'b0) begin
            errors++; $display("FAIL range_max_pos got (%0d,%0d) err %b exp (460,410) err 0", tile_xpos, tile_ypos, err);
        end
        step();
    endtask

    task automatic test_overflow;
        int lat, bc;
        convert(11'd2000, 11'd50, 7'd127, 5'd31, 5'd30, 5'd0, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL ovf_lat got %0d exp 32", lat); end
        checks++; if (err !== 1'b1 || tile_xpos !== 11'h7FF || tile_ypos !== 11'h7FF) begin
            errors++; $display("FAIL ovf_pos got (%h,%h) err %b exp (7ff,7ff) err 1", tile_xpos, tile_ypos, err);
        end
        step();
    endtask

    task automatic test_edges;
        int lat, bc;
        convert(11'd100, 11'd50, 7'd0, 5'd10, 5'd5, 5'd3, lat, bc);
        checks++; if (lat !== 7 || tile_xpos !== 11'd100 || tile_ypos !== 11'd50 || err !== 1'b0) begin
            errors++; $display("FAIL size0 got lat %0d (%0d,%0d) err %b exp lat 7 (100,50) err 0", lat, tile_xpos, tile_ypos, err);
        end
        step();
        convert(11'd100, 11'd50, 7'd40, 5'd0, 5'd0, 5'd0, lat, bc);
        checks++; if (lat !== 2 || err !== 1'b1 || tile_xpos !== 11'h7FF) begin
            errors++; $display("FAIL num0 got lat %0d x %h err %b exp lat 2 x 7ff err 1", lat, tile_xpos, err);
        end
        step();
    endtask

    task automatic test_back_to_back;
        int first, second, nvalid;
        int lat, bc;
        first = -1; second = -1; nvalid = 0;
        board_xpos = 11'd100; board_ypos = 11'd50;
        button_size = 7'd40; button_num = 5'd10;
        tile_x = 5'd2; tile_y = 5'd2;
        req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (valid) begin
                nvalid++;
                if (first < 0) first = i; else if (second < 0) second = i;
                checks++; if (tile_xpos !== 11'd180 || tile_ypos !== 11'd130 || err !== 1'b0) begin
                    errors++; $display("FAIL b2b_pos got (%0d,%0d) err %b exp (180,130) err 0", tile_xpos, tile_ypos, err);
                end
            end
        end
        req = 1'b0;
        checks++; if (first !== 5 || second !== 10 || nvalid !== 2) begin
            errors++; $display("FAIL b2b_timing got first %0d second %0d n %0d exp 5 10 2", first, second, nvalid);
        end
        for (int i = 0; i < 10; i++) step();
        // A request raised while busy must be dropped.
        board_xpos = 11'd100; board_ypos = 11'd50;
        button_size = 7'd40; button_num = 5'd10;
        tile_x = 5'd1; tile_y = 5'd1;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        tile_x = 5'd9; tile_y = 5'd9;
        req = 1'b1;
        step();
        req = 1'b0;
        nvalid = 0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (valid) begin
                nvalid++;
                checks++; if (tile_xpos !== 11'd140 || tile_ypos !== 11'd90) begin
                    errors++; $display("FAIL busy_req_pos got (%0d,%0d) exp (140,90)", tile_xpos, tile_ypos);
                end
            end
            step();
        end
        checks++; if (nvalid !== 1) begin errors++; $display("FAIL busy_req_count got %0d exp 1", nvalid); end
        bc = 0;
    endtask

    task automatic test_reset_mid;
        int nvalid, lat, bc;
        board_xpos = 11'd100; board_ypos = 11'd50;
        button_size = 7'd40; button_num = 5'd31;
        tile_x = 5'd20; tile_y = 5'd20;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_ctl got busy %b valid %b err %b exp 0 0 0", busy, valid, err);
        end
        checks++; if (tile_xpos !== 11'd0 || tile_ypos !== 11'd0) begin
            errors++; $display("FAIL midrst_pos got (%0d,%0d) exp (0,0)", tile_xpos, tile_ypos);
        end
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid) nvalid++;
            step();
        end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL midrst_valid got %0d exp 0", nvalid); end
        convert(11'd100, 11'd50, 7'd40, 5'd10, 5'd1, 5'd2, lat, bc);
        checks++; if (lat !== 4 || tile_xpos !== 11'd140 || tile_ypos !== 11'd130 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_next got lat %0d (%0d,%0d) err %b exp lat 4 (140,130) err 0", lat, tile_xpos, tile_ypos, err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_origin();
        test_asymmetric();
        test_range();
        test_overflow();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
